// File: rtl/axi_bus_arbiter.sv
// Round-robin AXI-lite bus arbiter: independent write and read channel engines,
// each holding its grant from arbitration until the response handshake or a watchdog release.
module axi_arb_channel #(
  parameter int MASTERS = 4,
  parameter int TIMEOUT = 256,
  parameter int IW      = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [MASTERS-1:0] i_req,
  input  logic               i_addr_hs,
  input  logic               i_resp_hs,
  output logic [MASTERS-1:0] o_grant,
  output logic [IW-1:0]      o_owner,
  output logic               o_taken,
  output logic               o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

  localparam int                 CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]      LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [MASTERS-1:0] ONE  = MASTERS'(1);

  state_t             r_state;
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [MASTERS-1:0] r_grant;
  logic [IW-1:0]      r_owner;
  logic               r_timeout;

  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_idx;
  logic               w_done;
  logic               w_expire;

  // First requester at or after the pointer, wrapping past the last master.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < MASTERS; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % MASTERS);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // A response together with the address handshake also closes the transaction.
  assign w_done   = ((r_state == S_ADDR) && i_addr_hs && i_resp_hs) ||
                    ((r_state == S_RESP) && i_resp_hs);
  assign w_expire = (TIMEOUT != 0) && (r_state != S_IDLE) && (r_cnt == LAST) && !w_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_owner   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_ADDR;
            r_grant <= ONE << w_win;
            r_owner <= w_win;
            r_ptr   <= (w_win == IW'(MASTERS - 1)) ? '0 : w_win + 1'b1;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (TIMEOUT != 0) r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end else if (w_expire) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_timeout <= 1'b1;
          end else if ((r_state == S_ADDR) && i_addr_hs) begin
            r_state <= S_RESP;
          end
        end
      endcase
    end
  end

  assign o_grant   = r_grant;
  assign o_owner   = r_owner;
  assign o_taken   = (r_state != S_IDLE);
  assign o_timeout = r_timeout;

endmodule

module axi_bus_arbiter #(
  parameter  int MASTERS = 4,
  parameter  int TIMEOUT = 256,
  localparam int IW      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic               axi_ACLK,
  input  logic               axi_ARESETN,
  input  logic [MASTERS-1:0] write_request_i,
  output logic [MASTERS-1:0] write_grant_o,
  output logic [IW-1:0]      write_owner_o,
  output logic               write_bus_taken_o,
  input  logic               write_addr_hs_i,
  input  logic               write_resp_hs_i,
  output logic               write_timeout_o,
  input  logic [MASTERS-1:0] read_request_i,
  output logic [MASTERS-1:0] read_grant_o,
  output logic [IW-1:0]      read_owner_o,
  output logic               read_bus_taken_o,
  input  logic               read_addr_hs_i,
  input  logic               read_resp_hs_i,
  output logic               read_timeout_o
);

  axi_arb_channel #(.MASTERS(MASTERS), .TIMEOUT(TIMEOUT), .IW(IW)) u_write (
    .i_clk     (axi_ACLK),
    .i_rst_n   (axi_ARESETN),
    .i_req     (write_request_i),
    .i_addr_hs (write_addr_hs_i),
    .i_resp_hs (write_resp_hs_i),
    .o_grant   (write_grant_o),
    .o_owner   (write_owner_o),
    .o_taken   (write_bus_taken_o),
    .o_timeout (write_timeout_o)
  );

  axi_arb_channel #(.MASTERS(MASTERS), .TIMEOUT(TIMEOUT), .IW(IW)) u_read (
    .i_clk     (axi_ACLK),
    .i_rst_n   (axi_ARESETN),
    .i_req     (read_request_i),
    .i_addr_hs (read_addr_hs_i),
    .i_resp_hs (read_resp_hs_i),
    .o_grant   (read_grant_o),
    .o_owner   (read_owner_o),
    .o_taken   (read_bus_taken_o),
    .o_timeout (read_timeout_o)
  );

endmodule
